pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed ID/EX latch so that one module can serve any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB):
- the payload width is configurable;
- the controlling stall bit is selected by parameter;
- it adds a valid bit, an exception flush and saturating stall/bubble performance counters.

It sits between two pipeline stages and is driven by the central stall controller's 6-bit stall vector.

## Interface
- DATA_W, 64, width of the opaque payload (aluop, alusel, operands, inst, link address packed by the instantiating stage).
- STAGE, 2, index of the upstream stall bit; stall[STAGE] gates the upstream stage, stall[STAGE+1] the downstream one. Legal range 0..4.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- stall  in  6  stall vector; 1 = Stop, 0 = NotStop.
- flush  in  1  exception/eret flush; squashes the stage.
- perf_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream instruction valid.
- in_data  in  DATA_W  upstream payload.
- in_wd  in  5  destination register address.
- in_wreg  in  1  register write enable.
- in_delayslot  in  1  upstream instruction is in a delay slot.
- next_in_delayslot  in  1  the next upstream instruction will be in a delay slot (branch resolved this cycle).
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered payload.
- out_wd  out  5  registered destination address.
- out_wreg  out  1  registered write enable.
- out_delayslot  out  1  registered delay-slot flag of the instruction now downstream.
- delayslot_fb  out  1  delay-slot feedback returned to the upstream stage.
- bubble_cnt  out  CNT_W  number of bubbles inserted.
- hold_cnt  out  CNT_W  number of hold cycles.

## Operation
Each rising edge takes exactly one action, in this priority order:
1. **rst.** All outputs go to 0: out_valid, out_data, out_wd, out_wreg, out_delayslot, delayslot_fb, bubble_cnt, hold_cnt.
2. **flush.** out_valid, out_data, out_wd, out_wreg, out_delayslot and delayslot_fb all go to 0. Counters are unchanged. A flush overrides any stall combination.
3. **Bubble** (stall[STAGE]=1, stall[STAGE+1]=0). Downstream receives a NOP: out_valid, out_data, out_wd, out_wreg and out_delayslot go to 0. delayslot_fb holds its value, so the stalled upstream branch keeps its delay-slot marking. bubble_cnt increments.
4. **Advance** (stall[STAGE]=0):
   - out_valid←in_valid, out_data←in_data, out_wd←in_wd, out_delayslot←in_delayslot, delayslot_fb←next_in_delayslot.
   - out_wreg←in_wreg & in_valid; an invalid instruction never writes.
5. **Hold** (stall[STAGE]=1, stall[STAGE+1]=1). All payload and flag outputs keep their values. hold_cnt increments.

Counter rules:
- Both counters saturate at 2^CNT_W−1 and never wrap.
- perf_clr zeroes both counters and takes priority over increment; perf_clr together with a bubble gives bubble_cnt=0 on the next cycle.
- rst takes priority over perf_clr.

Stall-vector combinations:
- stall[STAGE]=0 with stall[STAGE+1]=1 is illegal from the controller. The block treats it as advance.
- The verification bench flags it with an assertion.

## Timing
- Latency is 1 cycle from an in_* input to its out_* output on advance.
- All outputs are registered; there is no combinational path from input to output.
- A bubble appears at the outputs on the edge after stall[STAGE] rises while stall[STAGE+1] is low.
- Flush is effective on the same edge it is sampled. The upstream payload presented that cycle is discarded.
- rst mid-stall: outputs and counters are 0 on the next edge regardless of stall or flush. Normal operation resumes on the first edge with rst=0.
- Counters update on the same edge as the event they count.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with in_data=all-ones, in_valid=1 and stall=0 -> all outputs 0, including both counters.
- **Advance:** stall=0, in_valid=1, in_data=0x1234_5678_9ABC_DEF0, in_wd=5'd8, in_wreg=1, next_in_delayslot=1 -> after one edge out_data matches, out_wd=8, out_wreg=1, delayslot_fb=1.
- **Bubble then hold (STAGE=2):**
  - stall=6'b000111 for 1 cycle -> outputs are NOP, delayslot_fb is unchanged, bubble_cnt=1.
  - Then stall=6'b001111 for 3 cycles -> outputs are frozen and hold_cnt=3.
- **Flush priority:** flush=1 together with stall=6'b001111 and delayslot_fb=1 -> next edge gives out_valid=0, out_wreg=0, delayslot_fb=0, and hold_cnt does not increment.
- **Invalid write gating:** in_valid=0, in_wreg=1, stall=0 -> out_wreg=0 and out_valid=0.
- **Saturation and clear (CNT_W=4):**
  - 20 consecutive bubbles -> bubble_cnt stops at 15.
  - perf_clr together with a bubble -> bubble_cnt=0.
  - The next bubble -> bubble_cnt=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: payload/valid/flag latch with
// flush, bubble/hold stall handling and saturating bubble/hold counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int STAGE  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              perf_clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic              in_delayslot,
  input  logic              next_in_delayslot,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_wd,
  output logic              out_wreg,
  output logic              out_delayslot,
  output logic              delayslot_fb,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              ds_q, ds_d;
  logic              fb_q, fb_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  logic up_stall;
  logic dn_stall;

  assign up_stall = stall[STAGE];
  assign dn_stall = stall[STAGE+1];

  // Upstream running with downstream stopped cannot come from the controller;
  // it falls through to the advance branch.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    ds_d     = ds_q;
    fb_d     = fb_q;
    bubble_d = bubble_q;
    hold_d   = hold_q;

    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      wd_d    = '0;
      wreg_d  = 1'b0;
      ds_d    = 1'b0;
      fb_d    = 1'b0;
    end else if (up_stall && !dn_stall) begin
      valid_d  = 1'b0;
      data_d   = '0;
      wd_d     = '0;
      wreg_d   = 1'b0;
      ds_d     = 1'b0;
      bubble_d = (bubble_q == '1) ? bubble_q : bubble_q + CNT_W'(1);
    end else if (!up_stall) begin
      valid_d = in_valid;
      data_d  = in_data;
      wd_d    = in_wd;
      wreg_d  = in_wreg & in_valid;
      ds_d    = in_delayslot;
      fb_d    = next_in_delayslot;
    end else begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_W'(1);
    end

    if (perf_clr) begin
      bubble_d = '0;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      ds_q     <= 1'b0;
      fb_q     <= 1'b0;
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      ds_q     <= ds_d;
      fb_q     <= fb_d;
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_wd        = wd_q;
  assign out_wreg      = wreg_q;
  assign out_delayslot = ds_q;
  assign delayslot_fb  = fb_q;
  assign bubble_cnt    = bubble_q;
  assign hold_cnt      = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random legal stall traffic,
// two instances (16-bit and 4-bit counters) checked against a behavioural model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        perf_clr;
  logic        in_valid;
  logic [63:0] in_data;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic        in_delayslot;
  logic        next_in_delayslot;

  logic        out_valid, out_valid4;
  logic [63:0] out_data, out_data4;
  logic [4:0]  out_wd, out_wd4;
  logic        out_wreg, out_wreg4;
  logic        out_delayslot, out_delayslot4;
  logic        delayslot_fb, delayslot_fb4;
  logic [15:0] bubble_cnt, hold_cnt;
  logic [3:0]  bubble_cnt4, hold_cnt4;

  int checks;
  int failures;

  // model state
  logic        m_valid;
  logic [63:0] m_data;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic        m_ds;
  logic        m_fb;
  int          m_bub16, m_hold16, m_bub4, m_hold4;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .STAGE(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_data(in_data), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_delayslot(in_delayslot), .next_in_delayslot(next_in_delayslot),
    .out_valid(out_valid), .out_data(out_data), .out_wd(out_wd),
    .out_wreg(out_wreg), .out_delayslot(out_delayslot),
    .delayslot_fb(delayslot_fb), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .STAGE(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_data(in_data), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_delayslot(in_delayslot), .next_in_delayslot(next_in_delayslot),
    .out_valid(out_valid4), .out_data(out_data4), .out_wd(out_wd4),
    .out_wreg(out_wreg4), .out_delayslot(out_delayslot4),
    .delayslot_fb(delayslot_fb4), .bubble_cnt(bubble_cnt4), .hold_cnt(hold_cnt4)
  );

  always @(posedge clk) begin
    if (!rst)
      assert (!(!stall[2] && stall[3])) else $error("illegal stall vector %b", stall);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one action per edge in priority order rst > flush > bubble/advance/hold.
  function automatic int sat_inc(int v, int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic model_edge();
    bit up, dn;
    up = stall[2];
    dn = stall[3];
    if (rst) begin
      {m_valid, m_data, m_wd, m_wreg, m_ds, m_fb} = '0;
      m_bub16 = 0; m_hold16 = 0; m_bub4 = 0; m_hold4 = 0;
    end else begin
      if (flush) begin
        {m_valid, m_data, m_wd, m_wreg, m_ds, m_fb} = '0;
      end else if (!up) begin
        m_valid = in_valid;
        m_data  = in_data;
        m_wd    = in_wd;
        m_wreg  = in_wreg && in_valid;
        m_ds    = in_delayslot;
        m_fb    = next_in_delayslot;
      end else if (!dn) begin
        {m_valid, m_data, m_wd, m_wreg, m_ds} = '0;
        m_bub16 = sat_inc(m_bub16, 65535);
        m_bub4  = sat_inc(m_bub4, 15);
      end else begin
        m_hold16 = sat_inc(m_hold16, 65535);
        m_hold4  = sat_inc(m_hold4, 15);
      end
      if (perf_clr) begin
        m_bub16 = 0; m_hold16 = 0; m_bub4 = 0; m_hold4 = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check_eq({tag, ".data"}, out_data, m_data);
    check_eq({tag, ".wd"}, 64'(out_wd), 64'(m_wd));
    check_eq({tag, ".wreg"}, 64'(out_wreg), 64'(m_wreg));
    check_eq({tag, ".ds"}, 64'(out_delayslot), 64'(m_ds));
    check_eq({tag, ".fb"}, 64'(delayslot_fb), 64'(m_fb));
    check_eq({tag, ".bub16"}, 64'(bubble_cnt), 64'(m_bub16));
    check_eq({tag, ".hold16"}, 64'(hold_cnt), 64'(m_hold16));
    check_eq({tag, ".bub4"}, 64'(bubble_cnt4), 64'(m_bub4));
    check_eq({tag, ".hold4"}, 64'(hold_cnt4), 64'(m_hold4));
    check_eq({tag, ".data4"}, out_data4,
             {out_data4 === out_data ? out_data4 : m_data});
    check_eq({tag, ".flags4"},
             64'({out_valid4, out_wd4, out_wreg4, out_delayslot4, delayslot_fb4}),
             64'({m_valid, m_wd, m_wreg, m_ds, m_fb}));
  endtask

  // driver: advance one edge, update model, sample 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [63:0] d, input logic [4:0] wd,
                        input logic wreg, input logic ds, input logic nds);
    in_valid = v; in_data = d; in_wd = wd; in_wreg = wreg;
    in_delayslot = ds; next_in_delayslot = nds;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_bub16 = 0; m_hold16 = 0; m_bub4 = 0; m_hold4 = 0;
    {m_valid, m_data, m_wd, m_wreg, m_ds, m_fb} = '0;
    rst = 1'b1; stall = '0; flush = 1'b0; perf_clr = 1'b0;
    set_in(1'b1, '1, 5'h1f, 1'b1, 1'b1, 1'b1);

    // reset
    tick("rst0");
    tick("rst1");
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.data", out_data, 64'd0);
    check_eq("rst.bub", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;

    // advance
    set_in(1'b1, 64'h1234_5678_9ABC_DEF0, 5'd8, 1'b1, 1'b0, 1'b1);
    tick("adv");
    check_eq("adv.data", out_data, 64'h1234_5678_9ABC_DEF0);
    check_eq("adv.wd", 64'(out_wd), 64'd8);
    check_eq("adv.wreg", 64'(out_wreg), 64'd1);
    check_eq("adv.fb", 64'(delayslot_fb), 64'd1);

    // bubble then hold
    set_in(1'b1, 64'hdead_beef_0000_1111, 5'd3, 1'b1, 1'b1, 1'b0);
    stall = 6'b000111;
    tick("bub");
    check_eq("bub.valid", 64'(out_valid), 64'd0);
    check_eq("bub.fb", 64'(delayslot_fb), 64'd1);
    check_eq("bub.cnt", 64'(bubble_cnt), 64'd1);
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) tick("hold");
    check_eq("hold.cnt", 64'(hold_cnt), 64'd3);

    // flush priority: re-establish fb=1, then flush during hold
    stall = 6'b000000;
    set_in(1'b1, 64'h55, 5'd9, 1'b1, 1'b1, 1'b1);
    tick("pre_flush");
    stall = 6'b001111;
    flush = 1'b1;
    tick("flush");
    check_eq("flush.valid", 64'(out_valid), 64'd0);
    check_eq("flush.wreg", 64'(out_wreg), 64'd0);
    check_eq("flush.fb", 64'(delayslot_fb), 64'd0);
    check_eq("flush.hold", 64'(hold_cnt), 64'd3);
    flush = 1'b0;

    // invalid write gating
    stall = 6'b000000;
    set_in(1'b0, 64'h77, 5'd4, 1'b1, 1'b0, 1'b0);
    tick("inval");
    check_eq("inval.wreg", 64'(out_wreg), 64'd0);
    check_eq("inval.valid", 64'(out_valid), 64'd0);

    // saturation and clear
    stall = 6'b000111;
    for (int i = 0; i < 20; i++) tick("sat");
    check_eq("sat.bub4", 64'(bubble_cnt4), 64'd15);
    check_eq("sat.bub16", 64'(bubble_cnt), 64'd21);
    perf_clr = 1'b1;
    tick("clr");
    check_eq("clr.bub4", 64'(bubble_cnt4), 64'd0);
    perf_clr = 1'b0;
    tick("after_clr");
    check_eq("after_clr.bub4", 64'(bubble_cnt4), 64'd1);

    // hold saturation on the 4-bit instance
    stall = 6'b001111;
    for (int i = 0; i < 18; i++) tick("hsat");
    check_eq("hsat.hold4", 64'(hold_cnt4), 64'd15);

    // rst mid-stall with flush
    rst = 1'b1; flush = 1'b1;
    tick("rst_mid");
    rst = 1'b0; flush = 1'b0;

    // random legal traffic
    for (int i = 0; i < 600; i++) begin
      bit up, dn;
      up = 1'($urandom_range(0, 1));
      dn = up ? 1'($urandom_range(0, 1)) : 1'b0;
      stall = {2'($urandom_range(0, 3)), dn, up, 2'($urandom_range(0, 3))};
      if (!up && $urandom_range(0, 1) == 1) stall[5:4] = 2'b00;
      flush    = ($urandom_range(0, 15) == 0);
      perf_clr = ($urandom_range(0, 31) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
